cmos_capture_pack: RTL and testbench

Parametrised CMOS camera capture and pixel-packing block for the camera-to-DDR3-to-LCD video path. It sits between the raw camera pins and the DDR3 write port, and runs entirely in the camera pixel-clock domain. It discards the start-up frames after capture is enabled, optionally skips frames, and packs N camera bytes into one pixel word (or passes bytes through). It also checks line and frame geometry against the expected resolution.

---
 rtl/cmos_capture_pack.sv | 218 +++++++++++++++++++++
 tb/tb_cmos_capture_pack.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_capture_pack.sv
// CMOS camera capture front end: start-up frame discard, frame skipping,
// camera-byte to pixel-word packing and per-frame line/frame geometry checking.
module cmos_capture_pack #(
    parameter int DATA_W      = 8,
    parameter int PIX_W       = 16,
    parameter int WAIT_FRAMES = 10,
    parameter int CNT_W       = 13
) (
    input  logic              cam_pclk,
    input  logic              rst_n,
    input  logic              capture_start,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [DATA_W-1:0] cam_data,
    input  logic              mode,
    input  logic [3:0]        skip_n,
    input  logic [CNT_W-1:0]  h_pixel,
    input  logic [CNT_W-1:0]  v_pixel,
    output logic              cmos_frame_vsync,
    output logic              cmos_frame_href,
    output logic              cmos_frame_valid,
    output logic [PIX_W-1:0]  cmos_frame_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);

    localparam int PACK = PIX_W / DATA_W;
    localparam int BC_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int WC_W = $clog2(WAIT_FRAMES + 2);
    localparam int SH_W = (PACK > 1) ? (PIX_W - DATA_W) : DATA_W;

    typedef enum logic {S_WAIT, S_RUN} state_t;

    state_t state_q, state_d;

    logic              vsyncD0_q, vsyncD1_q, hrefD0_q, hrefD1_q;
    logic [DATA_W-1:0] dataD0_q;
    logic              fs, le, gateOn;

    logic [WC_W-1:0]   waitCnt_q, waitCnt_d;
    logic [3:0]        skipCnt_q, skipCnt_d;
    logic              keep_q, keep_d;
    logic [BC_W-1:0]   byteCnt_q, byteCnt_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic [PIX_W-1:0]  packNext;
    logic              rawValid;
    logic [PIX_W-1:0]  rawData;
    logic              valid_q, valid_d;
    logic [PIX_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]  pixCnt_q, pixCnt_d, lineCnt_q, lineCnt_d;
    logic              err_q, err_d;
    logic              frameDone_q, frameDone_d, frameErr_q, frameErr_d;
    logic [7:0]        frameCnt_q, frameCnt_d;

    assign fs = vsyncD0_q && !vsyncD1_q;
    assign le = !hrefD0_q && hrefD1_q;

    // Earlier bytes of a group sit in the upper bits, so the first byte ends up in the MSBs.
    generate
        if (PACK > 1) begin : g_pack
            assign packNext = {shift_q, dataD0_q};
        end else begin : g_nopack
            assign packNext = dataD0_q;
        end
    endgenerate

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!capture_start) begin
            state_d = S_WAIT;
        end else if (state_q == S_WAIT && fs && waitCnt_q == WC_W'(WAIT_FRAMES)) begin
            state_d = S_RUN;
        end
    end

    always_comb begin
        gateOn           = (state_q == S_RUN) && keep_q;
        cmos_frame_vsync = gateOn && vsyncD1_q;
        cmos_frame_href  = gateOn && hrefD1_q;
    end

    always_comb begin
        waitCnt_d   = waitCnt_q;
        skipCnt_d   = skipCnt_q;
        keep_d      = keep_q;
        byteCnt_d   = byteCnt_q;
        shift_d     = shift_q;
        rawValid    = 1'b0;
        rawData     = '0;
        pixCnt_d    = pixCnt_q;
        lineCnt_d   = lineCnt_q;
        err_d       = err_q;
        frameDone_d = 1'b0;
        frameErr_d  = 1'b0;
        frameCnt_d  = frameCnt_q;

        if (hrefD0_q) begin
            if (mode) begin
                rawValid  = 1'b1;
                rawData   = PIX_W'(dataD0_q);
                byteCnt_d = '0;
            end else begin
                shift_d = packNext[SH_W-1:0];
                if (byteCnt_q == BC_W'(PACK - 1)) begin
                    rawValid  = 1'b1;
                    rawData   = packNext;
                    byteCnt_d = '0;
                end else begin
                    byteCnt_d = byteCnt_q + 1'b1;
                end
            end
        end else begin
            byteCnt_d = '0;
        end

        valid_d = rawValid && gateOn;
        data_d  = valid_d ? rawData : '0;

        if (valid_d && pixCnt_q != '1) begin
            pixCnt_d = pixCnt_q + 1'b1;
        end
        if (le && gateOn) begin
            lineCnt_d = lineCnt_q + 1'b1;
            pixCnt_d  = '0;
            if (pixCnt_q != h_pixel) begin
                err_d = 1'b1;
            end
        end

        // Dropping capture_start outranks a coincident frame start, so the interrupted frame never reports.
        if (!capture_start) begin
            waitCnt_d = '0;
            skipCnt_d = '0;
            keep_d    = 1'b0;
            pixCnt_d  = '0;
            lineCnt_d = '0;
            err_d     = 1'b0;
        end else if (fs) begin
            if (state_q == S_WAIT) begin
                if (waitCnt_q == WC_W'(WAIT_FRAMES)) begin
                    keep_d    = 1'b1;
                    skipCnt_d = (skip_n == 4'd0) ? 4'd0 : 4'd1;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end else begin
                if (keep_q && lineCnt_q != '0) begin
                    frameDone_d = 1'b1;
                    frameErr_d  = err_q || (lineCnt_q != v_pixel);
                    frameCnt_d  = frameCnt_q + 8'd1;
                end
                keep_d    = (skipCnt_q == 4'd0);
                skipCnt_d = (skipCnt_q == skip_n) ? 4'd0 : skipCnt_q + 4'd1;
            end
            pixCnt_d  = '0;
            lineCnt_d = '0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsyncD0_q   <= 1'b0;
            vsyncD1_q   <= 1'b0;
            hrefD0_q    <= 1'b0;
            hrefD1_q    <= 1'b0;
            dataD0_q    <= '0;
            waitCnt_q   <= '0;
            skipCnt_q   <= '0;
            keep_q      <= 1'b0;
            byteCnt_q   <= '0;
            shift_q     <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            pixCnt_q    <= '0;
            lineCnt_q   <= '0;
            err_q       <= 1'b0;
            frameDone_q <= 1'b0;
            frameErr_q  <= 1'b0;
            frameCnt_q  <= '0;
        end else begin
            vsyncD0_q   <= cam_vsync;
            vsyncD1_q   <= vsyncD0_q;
            hrefD0_q    <= cam_href;
            hrefD1_q    <= hrefD0_q;
            dataD0_q    <= cam_data;
            waitCnt_q   <= waitCnt_d;
            skipCnt_q   <= skipCnt_d;
            keep_q      <= keep_d;
            byteCnt_q   <= byteCnt_d;
            shift_q     <= shift_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            pixCnt_q    <= pixCnt_d;
            lineCnt_q   <= lineCnt_d;
            err_q       <= err_d;
            frameDone_q <= frameDone_d;
            frameErr_q  <= frameErr_d;
            frameCnt_q  <= frameCnt_d;
        end
    end

    assign cmos_frame_valid = valid_q;
    assign cmos_frame_data  = data_q;
    assign frame_done       = frameDone_q;
    assign frame_err        = frameErr_q;
    assign frame_cnt        = frameCnt_q;

endmodule

// File: tb/tb_cmos_capture_pack.sv
// Directed self-checking bench for cmos_capture_pack: start-up discard, packing,
// byte mode, geometry errors, capture abort, async reset and frame skipping.
module tb_cmos_capture_pack;

    logic        cam_pclk = 1'b0;
    logic        rst_n;
    logic        capture_start;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        mode;
    logic [3:0]  skip_n;
    logic [12:0] h_pixel;
    logic [12:0] v_pixel;
    logic        cmos_frame_vsync;
    logic        cmos_frame_href;
    logic        cmos_frame_valid;
    logic [15:0] cmos_frame_data;
    logic        frame_done;
    logic        frame_err;
    logic [7:0]  frame_cnt;

    int vectors = 0;
    int miscompares = 0;
    int validTotal = 0;
    int doneTotal = 0;
    int hrefTotal = 0;
    int vsyncTotal = 0;
    int errStray = 0;
    logic lastErr = 1'b0;
    int cycleNo = 0;
    int firstByteCycle = 0;
    logic [15:0] dataLog[$];
    int validCycle[$];
    int v0, h0, s0, d0, idx;

    cmos_capture_pack #(
        .DATA_W(8), .PIX_W(16), .WAIT_FRAMES(10), .CNT_W(13)
    ) dut (
        .cam_pclk(cam_pclk),
        .rst_n(rst_n),
        .capture_start(capture_start),
        .cam_vsync(cam_vsync),
        .cam_href(cam_href),
        .cam_data(cam_data),
        .mode(mode),
        .skip_n(skip_n),
        .h_pixel(h_pixel),
        .v_pixel(v_pixel),
        .cmos_frame_vsync(cmos_frame_vsync),
        .cmos_frame_href(cmos_frame_href),
        .cmos_frame_valid(cmos_frame_valid),
        .cmos_frame_data(cmos_frame_data),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 cam_pclk = ~cam_pclk;

    always @(posedge cam_pclk) cycleNo <= cycleNo + 1;

    // Event tallies sampled mid-cycle; the directed steps compare deltas of these.
    always @(negedge cam_pclk) begin
        if (cmos_frame_valid === 1'b1) begin
            validTotal++;
            dataLog.push_back(cmos_frame_data);
            validCycle.push_back(cycleNo);
        end
        if (cmos_frame_href === 1'b1) hrefTotal++;
        if (cmos_frame_vsync === 1'b1) vsyncTotal++;
        if (frame_done === 1'b1) begin
            doneTotal++;
            lastErr = frame_err;
        end
        if (frame_err === 1'b1 && frame_done !== 1'b1) errStray++;
    end

    task automatic stepClocks(input int n);
        repeat (n) @(posedge cam_pclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One frame: vsync pulse (mode switched while it is high), then lines of bytes base+j*step.
    task automatic applyStimulus(input int nLines, input int nBytes, input int oddLine, input int oddBytes,
                                 input logic [7:0] base, input logic [7:0] step, input logic newMode);
        int nb;
        cam_vsync = 1'b1;
        stepClocks(1);
        mode = newMode;
        stepClocks(2);
        cam_vsync = 1'b0;
        stepClocks(2);
        for (int l = 0; l < nLines; l++) begin
            nb = (l == oddLine) ? oddBytes : nBytes;
            for (int j = 0; j < nb; j++) begin
                cam_href = 1'b1;
                cam_data = base + 8'(j) * step;
                if (l == 0 && j == 0) firstByteCycle = cycleNo;
                stepClocks(1);
            end
            cam_href = 1'b0;
            cam_data = 8'h00;
            stepClocks(3);
        end
        stepClocks(2);
    endtask

    initial begin
        rst_n = 1'b0;
        capture_start = 1'b0;
        cam_vsync = 1'b0;
        cam_href = 1'b0;
        cam_data = 8'h00;
        mode = 1'b0;
        skip_n = 4'd0;
        h_pixel = 13'd8;
        v_pixel = 13'd4;
        stepClocks(3);
        checkOutput("rst_vsync", 32'(cmos_frame_vsync), 0);
        checkOutput("rst_href", 32'(cmos_frame_href), 0);
        checkOutput("rst_valid", 32'(cmos_frame_valid), 0);
        checkOutput("rst_data", 32'(cmos_frame_data), 0);
        checkOutput("rst_done", 32'(frame_done), 0);
        checkOutput("rst_err", 32'(frame_err), 0);
        checkOutput("rst_cnt", 32'(frame_cnt), 0);
        rst_n = 1'b1;
        stepClocks(2);

        // Start-up discard: ten frames are swallowed, frame 11 is the first kept.
        capture_start = 1'b1;
        v0 = validTotal;
        for (int f = 0; f < 10; f++) applyStimulus(4, 16, -1, 0, 8'h10, 8'h01, 1'b0);
        checkOutput("discard_valid", 32'(validTotal - v0), 0);
        checkOutput("discard_done", 32'(doneTotal), 0);
        v0 = validTotal;
        applyStimulus(4, 16, -1, 0, 8'h10, 8'h01, 1'b0);
        checkOutput("f11_valid", 32'(validTotal - v0), 32);
        checkOutput("f11_done", 32'(doneTotal), 0);
        v0 = validTotal;
        s0 = vsyncTotal;
        applyStimulus(4, 16, -1, 0, 8'h10, 8'h01, 1'b0);
        checkOutput("f12_valid", 32'(validTotal - v0), 32);
        checkOutput("f12_vsync", 32'(vsyncTotal - s0), 3);
        checkOutput("f12_done", 32'(doneTotal), 1);
        checkOutput("f11_err", 32'(lastErr), 0);
        checkOutput("f12_cnt", 32'(frame_cnt), 1);

        // Byte order and a 17-byte line whose trailing byte is dropped.
        idx = dataLog.size();
        v0 = validTotal;
        applyStimulus(4, 16, 0, 17, 8'hAB, 8'h22, 1'b0);
        checkOutput("odd_valid", 32'(validTotal - v0), 32);
        checkOutput("order_first", 32'(dataLog[idx]), 32'h0000ABCD);
        checkOutput("order_last", 32'(dataLog[idx + 7]), 32'h000087A9);
        checkOutput("f13_cnt", 32'(frame_cnt), 2);

        // Byte mode: each byte becomes a zero-extended pixel two clocks later.
        idx = dataLog.size();
        v0 = validTotal;
        applyStimulus(4, 8, -1, 0, 8'h01, 8'h01, 1'b1);
        checkOutput("byte_valid", 32'(validTotal - v0), 32);
        for (int k = 0; k < 8; k++) checkOutput("byte_data", 32'(dataLog[idx + k]), 32'(k + 1));
        checkOutput("byte_latency", 32'(validCycle[idx] - firstByteCycle), 2);
        checkOutput("f14_cnt", 32'(frame_cnt), 3);
        checkOutput("odd_err", 32'(lastErr), 0);

        // Geometry errors: a 7-pixel line, then a clean frame, then a 3-line frame.
        v0 = validTotal;
        applyStimulus(4, 16, 2, 14, 8'h10, 8'h01, 1'b0);
        checkOutput("short_valid", 32'(validTotal - v0), 31);
        checkOutput("byte_err", 32'(lastErr), 0);
        applyStimulus(4, 16, -1, 0, 8'h10, 8'h01, 1'b0);
        checkOutput("short_line_err", 32'(lastErr), 1);
        checkOutput("f16_cnt", 32'(frame_cnt), 5);
        applyStimulus(3, 16, -1, 0, 8'h10, 8'h01, 1'b0);
        checkOutput("clean_err", 32'(lastErr), 0);
        applyStimulus(4, 16, -1, 0, 8'h10, 8'h01, 1'b0);
        checkOutput("short_frame_err", 32'(lastErr), 1);
        checkOutput("f18_cnt", 32'(frame_cnt), 7);

        // Abort: drop capture_start in the middle of a line.
        cam_vsync = 1'b1;
        stepClocks(3);
        cam_vsync = 1'b0;
        stepClocks(2);
        checkOutput("abort_pre_done", 32'(doneTotal), 8);
        checkOutput("abort_pre_cnt", 32'(frame_cnt), 8);
        for (int j = 0; j < 6; j++) begin
            cam_href = 1'b1;
            cam_data = 8'(j);
            stepClocks(1);
        end
        capture_start = 1'b0;
        for (int j = 0; j < 2; j++) begin
            cam_data = 8'(j + 6);
            stepClocks(1);
        end
        checkOutput("abort_valid", 32'(cmos_frame_valid), 0);
        checkOutput("abort_href", 32'(cmos_frame_href), 0);
        v0 = validTotal;
        d0 = doneTotal;
        for (int j = 0; j < 8; j++) begin
            cam_data = 8'(j + 8);
            stepClocks(1);
        end
        cam_href = 1'b0;
        stepClocks(5);
        applyStimulus(1, 2, -1, 0, 8'h10, 8'h01, 1'b0);
        checkOutput("abort_no_valid", 32'(validTotal - v0), 0);
        checkOutput("abort_no_done", 32'(doneTotal - d0), 0);

        // Re-enable: another ten frames must be discarded.
        capture_start = 1'b1;
        v0 = validTotal;
        for (int f = 0; f < 10; f++) applyStimulus(1, 2, -1, 0, 8'h10, 8'h01, 1'b0);
        checkOutput("rewarm_valid", 32'(validTotal - v0), 0);
        v0 = validTotal;
        applyStimulus(4, 16, -1, 0, 8'h10, 8'h01, 1'b0);
        checkOutput("rewarm_f11_valid", 32'(validTotal - v0), 32);

        // Async reset mid-line clears outputs without waiting for an edge.
        cam_vsync = 1'b1;
        stepClocks(3);
        cam_vsync = 1'b0;
        stepClocks(2);
        for (int j = 0; j < 5; j++) begin
            cam_href = 1'b1;
            cam_data = 8'(j);
            stepClocks(1);
        end
        checkOutput("pre_rst_href", 32'(cmos_frame_href), 1);
        checkOutput("pre_rst_cnt", 32'(frame_cnt), 9);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_href", 32'(cmos_frame_href), 0);
        checkOutput("arst_vsync", 32'(cmos_frame_vsync), 0);
        checkOutput("arst_valid", 32'(cmos_frame_valid), 0);
        checkOutput("arst_data", 32'(cmos_frame_data), 0);
        checkOutput("arst_cnt", 32'(frame_cnt), 0);
        stepClocks(1);
        rst_n = 1'b1;
        cam_href = 1'b0;
        stepClocks(5);

        // Skip: keep one frame in three after a fresh warm-up.
        skip_n = 4'd2;
        for (int f = 0; f < 10; f++) applyStimulus(1, 2, -1, 0, 8'h10, 8'h01, 1'b0);
        for (int i = 0; i < 9; i++) begin
            v0 = validTotal;
            h0 = hrefTotal;
            s0 = vsyncTotal;
            applyStimulus(4, 16, -1, 0, 8'h10, 8'h01, 1'b0);
            checkOutput("skip_valid", 32'(validTotal - v0), (i % 3 == 0) ? 32 : 0);
            checkOutput("skip_href", 32'(hrefTotal - h0), (i % 3 == 0) ? 64 : 0);
            checkOutput("skip_vsync", 32'(vsyncTotal - s0), (i % 3 == 0) ? 3 : 0);
            checkOutput("skip_cnt", 32'(frame_cnt), 32'((i + 2) / 3));
        end

        checkOutput("stray_err", 32'(errStray), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
